// File: rtl/program_sequencer.sv
// Run controller for TopLevel: launches P1..P3 in turn, waits for Ack, then sweeps
// each program's result window against the golden image and records the outcome.
module program_sequencer #(
  parameter int NUM_PROGS = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int START_CYC = 1,
  parameter int TIMEOUT   = 65535,
  parameter int P1_LO     = 30,
  parameter int P1_HI     = 59,
  parameter int P2_LO     = 94,
  parameter int P2_HI     = 123,
  parameter int P3_LO     = 192,
  parameter int P3_HI     = 194
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Go,
  output logic                 Start,
  input  logic                 Ack,
  output logic [ADDR_W-1:0]    DmAddr,
  input  logic [DATA_W-1:0]    DmData,
  output logic [ADDR_W-1:0]    GoldAddr,
  input  logic [DATA_W-1:0]    GoldData,
  output logic                 Busy,
  output logic                 Done,
  output logic [1:0]           ProgIdx,
  output logic [NUM_PROGS-1:0] PassMask,
  output logic [7:0]           ErrCount,
  output logic [15:0]          LastCycles,
  output logic                 TimedOut
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ARM,
    WAIT_ACK,
    CHECK,
    NEXT
  } state_t;

  localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT);
  localparam logic [3:0]  START_LAST = 4'(START_CYC - 1);
  localparam logic [1:0]  LAST_PROG  = 2'(NUM_PROGS - 1);

  state_t                 state_reg;
  logic                   start_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   timed_out_reg;
  logic                   match_reg;
  logic                   issue_done_reg;
  logic                   cmp_valid_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic [1:0]             prog_reg;
  logic [NUM_PROGS-1:0]   pass_reg;
  logic [7:0]             err_reg;
  logic [15:0]            last_reg;
  logic [15:0]            cyc_reg;
  logic [15:0]            cyc_next;
  logic [3:0]             start_cnt_reg;
  logic                   mismatch;

  // Window bounds per program index; index 3 is never reached and mirrors P3.
  logic [ADDR_W-1:0] win_lo [4];
  logic [ADDR_W-1:0] win_hi [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      localparam int LO = (gi == 0) ? P1_LO : (gi == 1) ? P2_LO : P3_LO;
      localparam int HI = (gi == 0) ? P1_HI : (gi == 1) ? P2_HI : P3_HI;
      assign win_lo[gi] = ADDR_W'(LO);
      assign win_hi[gi] = ADDR_W'(HI);
    end
  endgenerate

  always_comb begin
    cyc_next = (cyc_reg == 16'hFFFF) ? cyc_reg : cyc_reg + 16'd1;
    mismatch = cmp_valid_reg && (DmData != GoldData);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg      <= IDLE;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      timed_out_reg  <= 1'b0;
      match_reg      <= 1'b0;
      issue_done_reg <= 1'b0;
      cmp_valid_reg  <= 1'b0;
      addr_reg       <= '0;
      prog_reg       <= 2'd0;
      pass_reg       <= '0;
      err_reg        <= 8'd0;
      last_reg       <= 16'd0;
      cyc_reg        <= 16'd0;
      start_cnt_reg  <= 4'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Go) begin
            pass_reg      <= '0;
            err_reg       <= 8'd0;
            timed_out_reg <= 1'b0;
            prog_reg      <= 2'd0;
            start_reg     <= 1'b1;
            start_cnt_reg <= 4'd0;
            busy_reg      <= 1'b1;
            state_reg     <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (start_cnt_reg == START_LAST) begin
            start_reg <= 1'b0;
            state_reg <= ARM;
          end else begin
            start_cnt_reg <= start_cnt_reg + 4'd1;
          end
        end
        ARM: begin
          // Ack is deliberately not looked at here: it may still be high from the last program.
          cyc_reg   <= 16'd0;
          state_reg <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (Ack) begin
            last_reg       <= cyc_next;
            addr_reg       <= win_lo[prog_reg];
            match_reg      <= 1'b1;
            issue_done_reg <= 1'b0;
            cmp_valid_reg  <= 1'b0;
            state_reg      <= CHECK;
          end else if (cyc_next >= TIMEOUT_L) begin
            timed_out_reg <= 1'b1;
            last_reg      <= cyc_next;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            cyc_reg <= cyc_next;
          end
        end
        CHECK: begin
          if (mismatch) begin
            match_reg <= 1'b0;
            if (err_reg != 8'hFF) err_reg <= err_reg + 8'd1;
          end
          // Address stops at HI rather than incrementing, so HI=255 cannot wrap to 0.
          if (!issue_done_reg) begin
            cmp_valid_reg <= 1'b1;
            if (addr_reg == win_hi[prog_reg]) issue_done_reg <= 1'b1;
            else                              addr_reg <= addr_reg + 1'b1;
          end else begin
            cmp_valid_reg <= 1'b0;
            state_reg     <= NEXT;
          end
        end
        NEXT: begin
          pass_reg[prog_reg] <= match_reg;
          if (prog_reg == LAST_PROG) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            prog_reg      <= prog_reg + 2'd1;
            start_reg     <= 1'b1;
            start_cnt_reg <= 4'd0;
            state_reg     <= LAUNCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Start      = start_reg;
  assign DmAddr     = addr_reg;
  assign GoldAddr   = addr_reg;
  assign Busy       = busy_reg;
  assign Done       = done_reg;
  assign ProgIdx    = prog_reg;
  assign PassMask   = pass_reg;
  assign ErrCount   = err_reg;
  assign LastCycles = last_reg;
  assign TimedOut   = timed_out_reg;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a stub TopLevel answers each launch after a
// chosen delay, a reference model predicts each run, and a monitor checks what the DUT shows.
module tb_program_sequencer;

  localparam int START_CYC = 2;
  localparam int TIMEOUT   = 50;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Go = 1'b0;
  logic        Ack = 1'b0;
  logic        Start;
  logic [7:0]  DmAddr;
  logic [7:0]  DmData = 8'd0;
  logic [7:0]  GoldAddr;
  logic [7:0]  GoldData = 8'd0;
  logic        Busy;
  logic        Done;
  logic [1:0]  ProgIdx;
  logic [2:0]  PassMask;
  logic [7:0]  ErrCount;
  logic [15:0] LastCycles;
  logic        TimedOut;

  always #5 Clk = ~Clk;

  program_sequencer #(
    .START_CYC (START_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Go         (Go),
    .Start      (Start),
    .Ack        (Ack),
    .DmAddr     (DmAddr),
    .DmData     (DmData),
    .GoldAddr   (GoldAddr),
    .GoldData   (GoldData),
    .Busy       (Busy),
    .Done       (Done),
    .ProgIdx    (ProgIdx),
    .PassMask   (PassMask),
    .ErrCount   (ErrCount),
    .LastCycles (LastCycles),
    .TimedOut   (TimedOut)
  );

  // Synchronous read memories standing in for TopLevel data memory and the golden image.
  logic [7:0] dm_mem   [256];
  logic [7:0] gold_mem [256];
  always @(posedge Clk) begin
    DmData   <= dm_mem[DmAddr];
    GoldData <= gold_mem[GoldAddr];
  end

  typedef struct {
    logic [2:0] pass;
    int         err;
    bit         timed;
    int         starts;
  } rec_t;

  rec_t exp_run_q  [$];
  int   exp_last_q [$];
  int   exp_addr_q [$];

  int win_lo [3] = '{30, 94, 192};
  int win_hi [3] = '{59, 123, 194};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stub TopLevel: raises Ack on the stub_delay-th cycle after Start falls (0 = never).
  int stub_delay [3];
  bit stub_hold_p1 = 1'b0;
  int stub_prog = 0;
  int stub_idx  = 0;
  int stub_cnt  = 0;
  bit stub_armed = 1'b0;
  bit stub_drop  = 1'b0;
  bit stub_prev_start = 1'b0;

  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        Ack = 1'b0;
        stub_armed = 1'b0;
        stub_drop = 1'b0;
        stub_prev_start = 1'b0;
      end else begin
        if (stub_drop) begin
          Ack = 1'b0;
          stub_drop = 1'b0;
        end
        if (Start && !stub_prev_start) begin
          stub_idx = stub_prog;
          stub_prog++;
        end
        if (!Start && stub_prev_start) begin
          stub_cnt = (stub_idx < 3) ? stub_delay[stub_idx] : 0;
          stub_armed = (stub_cnt > 0);
        end else if (stub_armed) begin
          stub_cnt--;
          if (stub_cnt == 0) begin
            Ack = 1'b1;
            stub_armed = 1'b0;
            stub_drop = !(stub_hold_p1 && stub_idx == 0);
          end
        end
        stub_prev_start = Start;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an address, a launch or Done.
  initial begin
    int   prev_addr = 0;
    int   launches = 0;
    int   hi_len = 0;
    bit   prev_busy = 1'b0;
    bit   prev_start = 1'b0;
    int   e;
    rec_t r;
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset) begin
        launches = 0;
        hi_len = 0;
        prev_busy = 1'b0;
        prev_start = 1'b0;
        prev_addr = DmAddr;
      end else begin
        if (Busy && !prev_busy) launches = 0;
        if (Start && !prev_start) begin
          if (launches > 0) begin
            if (exp_last_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL last_cycles_q: got launch with LastCycles=%0d, expected no launch", LastCycles);
            end else begin
              e = exp_last_q.pop_front();
              chk("last_cycles_prev", int'(LastCycles), e);
            end
          end
          launches++;
        end
        if (Start) hi_len++;
        else if (prev_start) begin
          chk("start_len", hi_len, START_CYC);
          hi_len = 0;
        end
        if (Busy && int'(DmAddr) != prev_addr) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL addr_q: got DmAddr=%0d, expected no address", DmAddr);
          end else begin
            e = exp_addr_q.pop_front();
            chk("dm_addr", int'(DmAddr), e);
            chk("gold_addr", int'(GoldAddr), e);
          end
        end
        if (Done) begin
          if (exp_run_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_unexpected: got Done=1, expected no Done pulse");
          end else begin
            r = exp_run_q.pop_front();
            chk("pass_mask", int'(PassMask), int'(r.pass));
            chk("err_count", int'(ErrCount), r.err);
            chk("timed_out", int'(TimedOut), int'(r.timed));
            chk("start_pulses", launches, r.starts);
            chk("busy_at_done", int'(Busy), 0);
            $display("run done: mask=%b err=%0d last=%0d timeout=%0d starts=%0d",
                     PassMask, ErrCount, LastCycles, TimedOut, launches);
          end
          if (exp_last_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL last_cycles_q: got Done with LastCycles=%0d, expected none", LastCycles);
          end else begin
            e = exp_last_q.pop_front();
            chk("last_cycles_final", int'(LastCycles), e);
          end
        end
        prev_busy = Busy;
        prev_start = Start;
        prev_addr = DmAddr;
      end
    end
  end

  task automatic fill_mem(input int n_bad);
    int a;
    for (int i = 0; i < 256; i++) begin
      gold_mem[i] = 8'($urandom_range(0, 255));
      dm_mem[i] = gold_mem[i];
    end
    for (int i = 0; i < n_bad; i++) begin
      a = $urandom_range(0, 255);
      dm_mem[a] = gold_mem[a] ^ 8'($urandom_range(1, 255));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_start"}, int'(Start), 0);
    chk({tag, "_dmaddr"}, int'(DmAddr), 0);
    chk({tag, "_goldaddr"}, int'(GoldAddr), 0);
    chk({tag, "_busy"}, int'(Busy), 0);
    chk({tag, "_done"}, int'(Done), 0);
    chk({tag, "_progidx"}, int'(ProgIdx), 0);
    chk({tag, "_passmask"}, int'(PassMask), 0);
    chk({tag, "_errcount"}, int'(ErrCount), 0);
    chk({tag, "_lastcycles"}, int'(LastCycles), 0);
    chk({tag, "_timedout"}, int'(TimedOut), 0);
  endtask

  task automatic pulse_go();
    @(negedge Clk);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
  endtask

  // Reference model of one full run, then drive it and wait (bounded) for Done.
  task automatic run(input int d0, input int d1, input int d2, input bit stale, input bit go_mid);
    int   d [3];
    rec_t r;
    bit   match;
    int   cnt;
    d = '{d0, d1, d2};
    r.pass = 3'b000; r.err = 0; r.timed = 1'b0; r.starts = 0;
    for (int p = 0; p < 3; p++) begin
      r.starts++;
      if (d[p] == 0 || d[p] > TIMEOUT) begin
        r.timed = 1'b1;
        exp_last_q.push_back(TIMEOUT);
        break;
      end
      exp_last_q.push_back(d[p]);
      match = 1'b1;
      for (int a = win_lo[p]; a <= win_hi[p]; a++) begin
        exp_addr_q.push_back(a);
        if (dm_mem[a] != gold_mem[a]) begin
          match = 1'b0;
          if (r.err < 255) r.err++;
        end
      end
      r.pass[p] = match;
    end
    exp_run_q.push_back(r);
    stub_delay = d;
    stub_hold_p1 = stale;
    stub_prog = 0;
    pulse_go();
    if (go_mid) begin
      repeat (START_CYC + 3) @(negedge Clk);
      Go = 1'b1;
      @(negedge Clk);
      Go = 1'b0;
      chk("go_busy_progidx", int'(ProgIdx), 0);
      chk("go_busy_busy", int'(Busy), 1);
    end
    cnt = 0;
    while (!Done && cnt < 3000) begin
      @(negedge Clk);
      cnt++;
    end
    if (!Done) begin
      n_checks++; n_fail++;
      $display("FAIL done_wait: got no Done within %0d cycles, expected a Done pulse", cnt);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic reset_mid_check();
    int cnt;
    fill_mem(0);
    stub_delay = '{5, 5, 5};
    stub_hold_p1 = 1'b0;
    for (int a = win_lo[0]; a <= win_hi[0]; a++) exp_addr_q.push_back(a);
    exp_last_q.push_back(5);
    stub_prog = 0;
    pulse_go();
    cnt = 0;
    while (DmAddr != 8'd40 && cnt < 500) begin
      @(negedge Clk);
      cnt++;
    end
    chk("reach_addr_40", int'(DmAddr), 40);
    Reset = 1'b0;
    exp_addr_q.delete();
    exp_last_q.delete();
    @(negedge Clk);
    check_zero("mid_reset");
    @(negedge Clk);
    Reset = 1'b1;
    repeat (10) @(negedge Clk);
    $display("mid-check reset applied and released");
  endtask

  initial begin
    fill_mem(0);
    repeat (3) @(negedge Clk);
    check_zero("reset");
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    fill_mem(0);
    run(20, 20, 20, 1'b0, 1'b0);

    fill_mem(0);
    gold_mem[94] = 8'h5A;  dm_mem[94] = 8'h00;
    gold_mem[123] = 8'h5A; dm_mem[123] = 8'h00;
    run(20, 20, 20, 1'b0, 1'b0);

    fill_mem(0);
    run(20, 1, 15, 1'b1, 1'b0);

    fill_mem(2);
    run(10, 10, 0, 1'b0, 1'b0);

    reset_mid_check();
    fill_mem(1);
    run(8, 9, 10, 1'b0, 1'b0);

    fill_mem(1);
    run(20, 12, 7, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      int rd [3];
      for (int p = 0; p < 3; p++)
        rd[p] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 45);
      fill_mem($urandom_range(0, 6));
      run(rd[0], rd[1], rd[2], 1'b0, 1'b0);
    end

    chk("run_q_drained", exp_run_q.size(), 0);
    chk("last_q_drained", exp_last_q.size(), 0);
    chk("addr_q_drained", exp_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
